// File: rtl/lbuf_read_sched_pkg.sv
// lbuf_read_sched_pkg: lock state encodings, sync polarity and default 720p timing for the read scheduler
package lbuf_read_sched_pkg;

    typedef enum logic [1:0] {
        LOCK_UNLOCKED = 2'd0,
        LOCK_LOCKING  = 2'd1,
        LOCK_LOCKED   = 2'd2
    } lock_state_t;

    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int DEF_H_TOTAL     = 1650;
    localparam int DEF_H_ACTIVE    = 1280;
    localparam int DEF_H_SYNCLEN   = 40;
    localparam int DEF_H_AVIDSTART = 260;
    localparam int DEF_V_TOTAL     = 750;
    localparam int DEF_V_ACTIVE    = 720;
    localparam int DEF_V_SYNCLEN   = 5;
    localparam int DEF_V_AVIDSTART = 25;
    localparam int DEF_H_MULT      = 3;
    localparam int DEF_V_MULT      = 3;
    localparam int DEF_NUM_LBUF    = 40;
    localparam int DEF_V_LOCK_LINE = 0;
    localparam int DEF_LOCK_FRAMES = 4;

endpackage

// File: rtl/lbuf_read_sched_if.sv
// lbuf_read_sched_if: input frame pulse plus output timing and line-buffer read address bundle
interface lbuf_read_sched_if;
    logic        frame_start;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic [8:0]  hcnt_lbuf;
    logic [5:0]  vcnt_lbuf;
    logic [2:0]  hctr;
    logic [2:0]  vctr;
    logic        HSYNC;
    logic        VSYNC;
    logic        DE;
    logic        locked;

    modport master (
        input  frame_start,
        output hcnt, vcnt, hcnt_lbuf, vcnt_lbuf, hctr, vctr, HSYNC, VSYNC, DE, locked
    );

    modport slave (
        output frame_start,
        input  hcnt, vcnt, hcnt_lbuf, vcnt_lbuf, hctr, vctr, HSYNC, VSYNC, DE, locked
    );
endinterface

// File: rtl/lbuf_read_sched_repl_addr_ctr.sv
// lbuf_read_sched_repl_addr_ctr: replication phase counter driving a wrapping line-buffer address
module lbuf_read_sched_repl_addr_ctr #(
    parameter int AW = 9
) (
    input  logic          PCLK_ext,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          step,
    input  logic [2:0]    mult,
    input  logic [AW-1:0] wrap,
    output logic [2:0]    ctr,
    output logic [AW-1:0] addr
);
    logic last_phase;

    assign last_phase = ctr == mult - 3'd1;

    // Phase advances per step; address advances when the phase rolls over and wraps after the last buffer entry
    always_ff @(posedge PCLK_ext) begin
        if (!reset_n || clear) begin
            ctr  <= '0;
            addr <= '0;
        end else if (step) begin
            ctr <= last_phase ? '0 : ctr + 3'd1;
            if (last_phase) addr <= addr == wrap ? '0 : addr + AW'(1);
        end
    end
endmodule

// File: rtl/lbuf_read_sched.sv
// lbuf_read_sched: output timing and line-buffer read scheduler; LBUF_READ_FRAMELOCK_EN builds the input frame lock
module lbuf_read_sched
    import lbuf_read_sched_pkg::*;
#(
    parameter int H_TOTAL          = DEF_H_TOTAL,
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_SYNCLEN        = DEF_H_SYNCLEN,
    parameter int H_AVIDSTART      = DEF_H_AVIDSTART,
    parameter int V_TOTAL          = DEF_V_TOTAL,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_SYNCLEN        = DEF_V_SYNCLEN,
    parameter int V_AVIDSTART      = DEF_V_AVIDSTART,
    parameter int H_MULT           = DEF_H_MULT,
    parameter int V_MULT           = DEF_V_MULT,
    parameter int NUM_LINE_BUFFERS = DEF_NUM_LBUF,
    parameter int V_LOCK_LINE      = DEF_V_LOCK_LINE,
    parameter int LOCK_FRAMES      = DEF_LOCK_FRAMES
) (
    input  logic PCLK_ext,
    input  logic reset_n,
    lbuf_read_sched_if.master bus
);
    localparam logic [10:0] HT_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] VT_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END  = 11'(H_SYNCLEN);
    localparam logic [10:0] VS_END  = 11'(V_SYNCLEN);
    localparam logic [10:0] HA_PRE  = 11'(H_AVIDSTART - 1);
    localparam logic [10:0] HA_BEG  = 11'(H_AVIDSTART);
    localparam logic [10:0] HA_END  = 11'(H_AVIDSTART + H_ACTIVE);
    localparam logic [10:0] VA_PRE  = 11'(V_AVIDSTART - 1);
    localparam logic [10:0] VA_BEG  = 11'(V_AVIDSTART);
    localparam logic [10:0] VA_END  = 11'(V_AVIDSTART + V_ACTIVE);
    localparam logic [10:0] V_LOCK  = 11'(V_LOCK_LINE);

    logic [10:0] hcnt, vcnt, hcnt_n, vcnt_n;
    logic        hwrap, h_act, v_act, force_ctr, v_tick;
    logic        hsync_q, vsync_q, de_q;
    logic [2:0]  hctr, vctr;
    logic [8:0]  hcnt_lbuf;
    logic [5:0]  vcnt_lbuf;

    assign hwrap  = hcnt == HT_LAST;
    assign h_act  = hcnt >= HA_BEG && hcnt < HA_END;
    assign v_act  = vcnt >= VA_BEG && vcnt < VA_END;
    assign v_tick = hwrap && !force_ctr;

`ifdef LBUF_READ_FRAMELOCK_EN
    localparam logic [7:0] LOCK_CNT = 8'(LOCK_FRAMES);

    lock_state_t state, state_n;
    logic [7:0]  aligned_cnt, aligned_cnt_n;
    logic        aligned;

    assign aligned = vcnt == V_LOCK && hcnt <= 11'd1;

    // Lock state and run of consecutive aligned frames
    always_ff @(posedge PCLK_ext) begin
        if (!reset_n) begin
            state       <= LOCK_UNLOCKED;
            aligned_cnt <= '0;
        end else begin
            state       <= state_n;
            aligned_cnt <= aligned_cnt_n;
        end
    end

    // Classify each frame_start; any misaligned or first pulse re-forces the counters
    always_comb begin
        state_n       = state;
        aligned_cnt_n = aligned_cnt;
        force_ctr     = 1'b0;
        if (bus.frame_start) begin
            if (state != LOCK_UNLOCKED && aligned) begin
                if (state == LOCK_LOCKING) begin
                    aligned_cnt_n = aligned_cnt + 8'd1;
                    if (aligned_cnt_n == LOCK_CNT) state_n = LOCK_LOCKED;
                end
            end else begin
                force_ctr     = 1'b1;
                state_n       = LOCK_LOCKING;
                aligned_cnt_n = '0;
            end
        end
    end

    assign bus.locked = state == LOCK_LOCKED;
`else
    logic unused_lock;

    assign unused_lock = bus.frame_start & (LOCK_FRAMES > 0);
    assign force_ctr   = 1'b0;
    assign bus.locked  = 1'b1;
`endif

    // Free-running raster position, overridden by a frame lock force
    always_comb begin
        hcnt_n = hwrap ? '0 : hcnt + 11'd1;
        vcnt_n = !hwrap ? vcnt : (vcnt == VT_LAST ? '0 : vcnt + 11'd1);
        if (force_ctr) begin
            hcnt_n = '0;
            vcnt_n = V_LOCK;
        end
    end

    // Stage-0 counters and stage-1 syncs/DE decoded from them
    always_ff @(posedge PCLK_ext) begin
        if (!reset_n) begin
            hcnt    <= '0;
            vcnt    <= '0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            de_q    <= 1'b0;
        end else begin
            hcnt    <= hcnt_n;
            vcnt    <= vcnt_n;
            hsync_q <= hcnt < HS_END ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q <= vcnt < VS_END ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            de_q    <= h_act && v_act;
        end
    end

    lbuf_read_sched_repl_addr_ctr #(.AW(9)) u_h_addr (
        .PCLK_ext (PCLK_ext),
        .reset_n  (reset_n),
        .clear    (hcnt == HA_PRE),
        .step     (h_act),
        .mult     (3'(H_MULT)),
        .wrap     (9'd511),
        .ctr      (hctr),
        .addr     (hcnt_lbuf)
    );

    lbuf_read_sched_repl_addr_ctr #(.AW(6)) u_v_addr (
        .PCLK_ext (PCLK_ext),
        .reset_n  (reset_n),
        .clear    (v_tick && vcnt == VA_PRE),
        .step     (v_tick && v_act),
        .mult     (3'(V_MULT)),
        .wrap     (6'(NUM_LINE_BUFFERS - 1)),
        .ctr      (vctr),
        .addr     (vcnt_lbuf)
    );

    assign bus.hcnt      = hcnt;
    assign bus.vcnt      = vcnt;
    assign bus.hcnt_lbuf = hcnt_lbuf;
    assign bus.vcnt_lbuf = vcnt_lbuf;
    assign bus.hctr      = hctr;
    assign bus.vctr      = vctr;
    assign bus.HSYNC     = hsync_q;
    assign bus.VSYNC     = vsync_q;
    assign bus.DE        = de_q;
endmodule

// File: tb/tb_lbuf_read_sched.sv
// tb_lbuf_read_sched: raster-position model plus hand-computed sequences for lbuf_read_sched (lock checks when LBUF_READ_FRAMELOCK_EN)
module tb_lbuf_read_sched;
    localparam int HT = 20, HA = 12, HS = 2, HAS = 4, HM = 3;
    localparam int VT = 10, VA = 6, VS = 1, VAS = 2, VM = 2;
    localparam int NLB = 2, VLL = 0, LF = 4;
`ifdef LBUF_READ_FRAMELOCK_EN
    localparam int LOCK_MODE = 1;
`else
    localparam int LOCK_MODE = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    lbuf_read_sched_if bus();

    lbuf_read_sched #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNCLEN(HS), .H_AVIDSTART(HAS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNCLEN(VS), .V_AVIDSTART(VAS),
        .H_MULT(HM), .V_MULT(VM), .NUM_LINE_BUFFERS(NLB),
        .V_LOCK_LINE(VLL), .LOCK_FRAMES(LF)
    ) dut (
        .PCLK_ext (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected raster position and what the spec derives from it
    int mh, mv, ph, pv, mstate, acnt, kk, ll;
    bit first_line, first_frame, st1_valid, addr_chk, frc;

    always @(posedge clk) begin
        if (!reset_n) begin
            mh = 0; mv = 0; first_line = 1; first_frame = 1;
            st1_valid = 0; addr_chk = 1; mstate = 0; acnt = 0;
        end else begin
            ph = mh; pv = mv; st1_valid = 1; frc = 0;
            if (LOCK_MODE == 1 && bus.frame_start) begin
                if (mstate != 0 && mv == VLL && mh <= 1) begin
                    if (mstate == 1) begin
                        acnt = acnt + 1;
                        if (acnt == LF) mstate = 2;
                    end
                end else begin
                    frc = 1; mstate = 1; acnt = 0;
                end
            end
            if (frc) begin
                mh = 0; mv = VLL; addr_chk = 0;
            end else if (mh == HT - 1) begin
                mh = 0; first_line = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
                if (mv == 0) first_frame = 0;
            end else begin
                mh = mh + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_hcnt", int'(bus.hcnt), mh);
            chk("m_vcnt", int'(bus.vcnt), mv);
            chk("m_hsync", int'(bus.HSYNC), st1_valid ? int'(ph >= HS) : 1);
            chk("m_vsync", int'(bus.VSYNC), st1_valid ? int'(pv >= VS) : 1);
            chk("m_de", int'(bus.DE), st1_valid ? int'(ph >= HAS && ph < HAS + HA && pv >= VAS && pv < VAS + VA) : 0);
            chk("m_locked", int'(bus.locked), LOCK_MODE == 1 ? int'(mstate == 2) : 1);
            if (addr_chk) begin
                kk = (mh >= HAS) ? ((mh - HAS < HA) ? mh - HAS : HA) : (first_line ? 0 : HA);
                ll = (mv >= VAS) ? ((mv - VAS < VA) ? mv - VAS : VA) : (first_frame ? 0 : VA);
                chk("m_hctr", int'(bus.hctr), kk % HM);
                chk("m_hcnt_lbuf", int'(bus.hcnt_lbuf), (kk / HM) % 512);
                chk("m_vctr", int'(bus.vctr), ll % VM);
                chk("m_vcnt_lbuf", int'(bus.vcnt_lbuf), (ll / VM) % NLB);
            end
        end
    end

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(int'(bus.hcnt) == h && int'(bus.vcnt) == v) && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 500) begin
            fails++;
            $display("FAIL wait_pos: hcnt=%0d vcnt=%0d not reached, got hcnt=%0d vcnt=%0d", h, v, bus.hcnt, bus.vcnt);
        end
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    int hl[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    int vl[6]  = '{0, 0, 1, 1, 0, 0};
    int hs_lo, vs_lo, de_hi;

    initial begin
        bus.frame_start = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_hcnt", int'(bus.hcnt), 0);
        chk("rst_vcnt", int'(bus.vcnt), 0);
        chk("rst_hsync", int'(bus.HSYNC), 1);
        chk("rst_vsync", int'(bus.VSYNC), 1);
        chk("rst_de", int'(bus.DE), 0);
        chk("rst_locked", int'(bus.locked), LOCK_MODE == 1 ? 0 : 1);
        reset_n = 1'b1;

        wait_pos(HAS, 2);
        for (int i = 0; i < 12; i++) begin
            chk("seq_hcnt_lbuf", int'(bus.hcnt_lbuf), hl[i]);
            chk("seq_hctr", int'(bus.hctr), i % 3);
            @(negedge clk);
        end
        for (int l = 2; l < 8; l++) begin
            wait_pos(5, l);
            chk("seq_vcnt_lbuf", int'(bus.vcnt_lbuf), vl[l - 2]);
            chk("seq_vctr", int'(bus.vctr), (l - 2) % 2);
        end

        wait_pos(0, 0);
        hs_lo = 0; vs_lo = 0; de_hi = 0;
        for (int i = 0; i < HT * VT; i++) begin
            hs_lo += int'(!bus.HSYNC);
            vs_lo += int'(!bus.VSYNC);
            de_hi += int'(bus.DE);
            @(negedge clk);
        end
        chk("frame_hsync_low", hs_lo, 20);
        chk("frame_vsync_low", vs_lo, 20);
        chk("frame_de_high", de_hi, 72);

        if (LOCK_MODE == 0) begin
            wait_pos(3, 5);
            pulse_fs();
            chk("free_fs_hcnt", int'(bus.hcnt), 4);
            chk("free_fs_vcnt", int'(bus.vcnt), 5);
            chk("free_fs_locked", int'(bus.locked), 1);
            wait_pos(19, 6);
            pulse_fs();
            chk("free_wrap_hcnt", int'(bus.hcnt), 0);
            chk("free_wrap_vcnt", int'(bus.vcnt), 7);
        end else begin
            wait_pos(3, 5);
            pulse_fs();
            chk("lock_force_hcnt", int'(bus.hcnt), 0);
            chk("lock_force_vcnt", int'(bus.vcnt), VLL);
            chk("lock_force_locked", int'(bus.locked), 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                wait_pos(0, VLL);
                pulse_fs();
                chk("lock_aligned_hcnt", int'(bus.hcnt), 1);
                chk("lock_aligned_locked", int'(bus.locked), i == 3 ? 1 : 0);
            end
            @(negedge clk);
            wait_pos(0, 3);
            pulse_fs();
            chk("lock_shift_locked", int'(bus.locked), 0);
            chk("lock_shift_vcnt", int'(bus.vcnt), VLL);
            @(negedge clk);
            wait_pos(HT - 1, 6);
            pulse_fs();
            chk("lock_wrap_hcnt", int'(bus.hcnt), 0);
            chk("lock_wrap_vcnt", int'(bus.vcnt), VLL);
            @(negedge clk);
            chk("lock_wrap_next_hcnt", int'(bus.hcnt), 1);
            chk("lock_wrap_next_vcnt", int'(bus.vcnt), VLL);
        end

        wait_pos(7, 3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_hcnt", int'(bus.hcnt), 0);
        chk("mid_rst_vcnt", int'(bus.vcnt), 0);
        chk("mid_rst_hctr", int'(bus.hctr), 0);
        chk("mid_rst_vctr", int'(bus.vctr), 0);
        chk("mid_rst_hcnt_lbuf", int'(bus.hcnt_lbuf), 0);
        chk("mid_rst_vcnt_lbuf", int'(bus.vcnt_lbuf), 0);
        chk("mid_rst_hsync", int'(bus.HSYNC), 1);
        chk("mid_rst_vsync", int'(bus.VSYNC), 1);
        chk("mid_rst_de", int'(bus.DE), 0);
        reset_n = 1'b1;
        repeat (2 * HT * VT) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule
